// File: rtl/lc3b_types.sv
// Shared LC-3b control types: opcodes, ALU ops, address-mux encodings, control word.
// No logic; pure typedefs and a small helper.
// Backpressure: n/a.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [3:0] {
        op_br   = 4'h0, op_add  = 4'h1, op_ldb  = 4'h2, op_stb  = 4'h3,
        op_jsr  = 4'h4, op_and  = 4'h5, op_ldr  = 4'h6, op_str  = 4'h7,
        op_rti  = 4'h8, op_not  = 4'h9, op_ldi  = 4'ha, op_sti  = 4'hb,
        op_jmp  = 4'hc, op_shf  = 4'hd, op_lea  = 4'he, op_trap = 4'hf
    } lc3b_opcode;

    // alu_pass is encoded as zero so an all-zero word is a harmless pass-through
    typedef enum logic [1:0] {
        alu_pass = 2'b00,
        alu_add  = 2'b01,
        alu_and  = 2'b10,
        alu_not  = 2'b11
    } lc3b_aluop;

    typedef enum logic [1:0] {
        addr2_none = 2'b00,
        addr2_off6 = 2'b01,
        addr2_off9 = 2'b10
    } lc3b_addr2mux_sel;

    typedef struct packed {
        lc3b_opcode       opcode;
        lc3b_aluop        aluop;
        logic             load_regfile;
        logic             load_cc;
        logic             sr2mux_sel;
        logic             mem_read;
        logic             mem_write;
        logic             regfilemux_sel;
        logic             addr1mux_sel;
        lc3b_addr2mux_sel addr2mux_sel;
    } lc3b_control_word;

    function automatic logic is_mem_op(input lc3b_control_word w);
        return w.mem_read | w.mem_write;
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational LC-3b decode: instr -> control word plus legal flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether the word is consumed.
module control_decode
    import lc3b_types::*;
(
    input  lc3b_word         instr,
    output lc3b_control_word ctrl,
    output logic             legal
);

    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[11:6], instr[4:0]};

    always_comb begin
        ctrl        = '0;
        legal       = 1'b1;
        ctrl.opcode = lc3b_opcode'(instr[15:12]);
        ctrl.aluop  = alu_pass;
        case (lc3b_opcode'(instr[15:12]))
            op_add, op_and: begin
                ctrl.aluop        = (instr[15:12] == op_add) ? alu_add : alu_and;
                ctrl.load_regfile = 1'b1;
                ctrl.load_cc      = 1'b1;
                ctrl.sr2mux_sel   = instr[5];
            end
            op_not: begin
                ctrl.aluop        = alu_not;
                ctrl.load_regfile = 1'b1;
                ctrl.load_cc      = 1'b1;
            end
            op_ldr: begin
                ctrl.mem_read       = 1'b1;
                ctrl.load_regfile   = 1'b1;
                ctrl.regfilemux_sel = 1'b1;
                ctrl.load_cc        = 1'b1;
                ctrl.addr1mux_sel   = 1'b1;
                ctrl.addr2mux_sel   = addr2_off6;
            end
            op_str: begin
                ctrl.mem_write    = 1'b1;
                ctrl.addr1mux_sel = 1'b1;
                ctrl.addr2mux_sel = addr2_off6;
            end
            op_br: begin
                ctrl.addr2mux_sel = addr2_off9;
            end
            default: begin
                // unsupported opcodes travel as an all-zero, invalid word
                ctrl  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/control_pipe.sv
// LC-3b control-word pipeline (EX..MEM..WB) with memory stall and flush; perf counters under CTRL_PIPE_PERF_EN.
// Latency: accept -> stage 0 in 1 cycle, -> WB in STAGES cycles when unstalled.
// Backpressure: in_ready drops while MEM waits on mem_resp; flush outranks the stall.
module control_pipe
    import lc3b_types::*;
#(
    parameter int STAGES = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  lc3b_word                       instr,
    input  logic                           flush,
    input  logic                           mem_resp,
    output lc3b_control_word [STAGES-1:0]  ctrl_out,
    output logic [STAGES-1:0]              valid_out,
    output logic                           illegal_op,
    output logic [2:0]                     inflight
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [15:0]                    stall_cycles,
    output logic [15:0]                    retired
`endif
);

    localparam int MEM = STAGES - 2;
    localparam int WB  = STAGES - 1;

    lc3b_control_word                dec_word;
    logic                            dec_legal;
    logic                            mem_stall;
    logic                            accept;
    lc3b_control_word [STAGES-1:0]   ctrl_d;
    logic [STAGES-1:0]               valid_d;

    control_decode u_decode (
        .instr (instr),
        .ctrl  (dec_word),
        .legal (dec_legal)
    );

    assign mem_stall = valid_out[MEM] & is_mem_op(ctrl_out[MEM]) & ~mem_resp;
    assign in_ready  = ~mem_stall;
    assign accept    = in_valid & ~mem_stall & ~flush;

    function automatic logic [2:0] popcount(input logic [STAGES-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int k = 0; k < STAGES; k++) n = n + {2'b00, v[k]};
        return n;
    endfunction

    always_comb begin
        ctrl_d  = ctrl_out;
        valid_d = valid_out;
        // WB takes a bubble whenever MEM is still waiting, flushed or not
        ctrl_d[WB]  = mem_stall ? '0 : ctrl_out[MEM];
        valid_d[WB] = valid_out[MEM] & ~mem_stall;
        if (flush) begin
            for (int k = 0; k < WB; k++) begin
                ctrl_d[k]  = '0;
                valid_d[k] = 1'b0;
            end
        end else if (!mem_stall) begin
            for (int k = WB - 1; k > 0; k--) begin
                ctrl_d[k]  = ctrl_out[k-1];
                valid_d[k] = valid_out[k-1];
            end
            ctrl_d[0]  = dec_word;
            valid_d[0] = in_valid & dec_legal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_out   <= '0;
            valid_out  <= '0;
            illegal_op <= 1'b0;
            inflight   <= '0;
        end else begin
            ctrl_out   <= ctrl_d;
            valid_out  <= valid_d;
            illegal_op <= accept & ~dec_legal;
            inflight   <= popcount(valid_d);
        end
    end

`ifdef CTRL_PIPE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            retired      <= '0;
        end else begin
            if (mem_stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
            if (valid_out[WB] && retired != 16'hFFFF) retired <= retired + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_control_pipe.sv
// Scoreboard bench for control_pipe at STAGES=3 and STAGES=5 driven by shared stimulus.
module tb_control_pipe;
    import lc3b_types::*;

    localparam int W = $bits(lc3b_control_word);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic     rst = 1'b1, in_valid = 1'b0, flush = 1'b0, mem_resp = 1'b0;
    lc3b_word instr = '0;

    logic rdy3, rdy5, ill3, ill5;
    lc3b_control_word [2:0] ctrl3;
    lc3b_control_word [4:0] ctrl5;
    logic [2:0] v3;
    logic [4:0] v5;
    logic [2:0] inf3, inf5;
`ifdef CTRL_PIPE_PERF_EN
    logic [15:0] stc3, ret3, stc5, ret5;
`endif

    control_pipe #(.STAGES(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3), .instr(instr),
        .flush(flush), .mem_resp(mem_resp), .ctrl_out(ctrl3), .valid_out(v3),
        .illegal_op(ill3), .inflight(inf3)
`ifdef CTRL_PIPE_PERF_EN
        , .stall_cycles(stc3), .retired(ret3)
`endif
    );

    control_pipe #(.STAGES(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy5), .instr(instr),
        .flush(flush), .mem_resp(mem_resp), .ctrl_out(ctrl5), .valid_out(v5),
        .illegal_op(ill5), .inflight(inf5)
`ifdef CTRL_PIPE_PERF_EN
        , .stall_cycles(stc5), .retired(ret5)
`endif
    );

    typedef struct packed {
        logic [4:0]     valid;
        logic [5*W-1:0] words;
        logic           ill;
        logic [2:0]     inflight;
        logic           rdy;
        logic [15:0]    stc;
        logic [15:0]    ret;
    } snap_t;

    snap_t q3[$];
    snap_t q5[$];

    int checks = 0;
    int errors = 0;

    // reference pipeline state, one row per DUT: [0] is STAGES=3, [1] is STAGES=5
    logic             m_v[2][5];
    lc3b_control_word m_w[2][5];
    logic             m_ill[2];
    int               m_stc[2];
    int               m_ret[2];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // decode table written from the ISA opcode numbers
    function automatic lc3b_control_word ref_decode(input logic [15:0] i, output logic legal);
        lc3b_control_word w;
        w        = '0;
        legal    = 1'b1;
        w.opcode = lc3b_opcode'(i[15:12]);
        case (i[15:12])
            4'h1: begin w.aluop = alu_add; w.load_regfile = 1; w.load_cc = 1; w.sr2mux_sel = i[5]; end
            4'h5: begin w.aluop = alu_and; w.load_regfile = 1; w.load_cc = 1; w.sr2mux_sel = i[5]; end
            4'h9: begin w.aluop = alu_not; w.load_regfile = 1; w.load_cc = 1; end
            4'h6: begin
                w.mem_read = 1; w.load_regfile = 1; w.regfilemux_sel = 1; w.load_cc = 1;
                w.addr1mux_sel = 1; w.addr2mux_sel = addr2_off6;
            end
            4'h7: begin w.mem_write = 1; w.addr1mux_sel = 1; w.addr2mux_sel = addr2_off6; end
            4'h0: w.addr2mux_sel = addr2_off9;
            default: begin w = '0; legal = 1'b0; end
        endcase
        return w;
    endfunction

    task automatic model_step(input int d, input int s, input logic v, input logic [15:0] ins,
                              input logic fl, input logic mr, input logic r, output snap_t e);
        logic stall, legal, mem_wait;
        lc3b_control_word dw;
        int cnt;
        stall = m_v[d][s-2] && (m_w[d][s-2].mem_read || m_w[d][s-2].mem_write) && !mr;
        dw    = ref_decode(ins, legal);
        if (r) begin
            for (int k = 0; k < 5; k++) begin m_v[d][k] = 0; m_w[d][k] = '0; end
            m_ill[d] = 0; m_stc[d] = 0; m_ret[d] = 0;
        end else begin
            if (stall && m_stc[d] < 65535) m_stc[d]++;
            if (m_v[d][s-1] && m_ret[d] < 65535) m_ret[d]++;
            m_v[d][s-1] = m_v[d][s-2] && !stall;
            m_w[d][s-1] = stall ? '0 : m_w[d][s-2];
            m_ill[d] = 0;
            if (fl) begin
                for (int k = 0; k < s - 1; k++) begin m_v[d][k] = 0; m_w[d][k] = '0; end
            end else if (!stall) begin
                for (int k = s - 2; k > 0; k--) begin m_v[d][k] = m_v[d][k-1]; m_w[d][k] = m_w[d][k-1]; end
                m_v[d][0] = v && legal;
                m_w[d][0] = dw;
                m_ill[d]  = v && !legal;
            end
        end
        e = '0;
        cnt = 0;
        for (int k = 0; k < s; k++) begin
            e.valid[k]        = m_v[d][k];
            e.words[k*W +: W] = m_w[d][k];
            if (m_v[d][k]) cnt++;
        end
        mem_wait   = m_v[d][s-2] && (m_w[d][s-2].mem_read || m_w[d][s-2].mem_write) && !mr;
        e.ill      = m_ill[d];
        e.inflight = cnt[2:0];
        e.rdy      = !mem_wait;
        e.stc      = m_stc[d][15:0];
        e.ret      = m_ret[d][15:0];
    endtask

    task automatic cyc(input logic v, input logic [15:0] ins, input logic fl, input logic mr, input logic r);
        snap_t e;
        @(negedge clk);
        in_valid = v; instr = ins; flush = fl; mem_resp = mr; rst = r;
        model_step(0, 3, v, ins, fl, mr, r, e); q3.push_back(e);
        model_step(1, 5, v, ins, fl, mr, r, e); q5.push_back(e);
    endtask

    task automatic look;
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        snap_t e;
        #1;
        if (q3.size() > 0) begin
            e = q3.pop_front();
            chk("s3_valid", 128'(v3), 128'(e.valid[2:0]));
            chk("s3_ctrl", 128'(ctrl3), 128'(e.words[3*W-1:0]));
            chk("s3_illegal", 128'(ill3), 128'(e.ill));
            chk("s3_inflight", 128'(inf3), 128'(e.inflight));
            chk("s3_in_ready", 128'(rdy3), 128'(e.rdy));
`ifdef CTRL_PIPE_PERF_EN
            chk("s3_stall_cycles", 128'(stc3), 128'(e.stc));
            chk("s3_retired", 128'(ret3), 128'(e.ret));
`endif
        end
        if (q5.size() > 0) begin
            e = q5.pop_front();
            chk("s5_valid", 128'(v5), 128'(e.valid));
            chk("s5_ctrl", 128'(ctrl5), 128'(e.words));
            chk("s5_illegal", 128'(ill5), 128'(e.ill));
            chk("s5_inflight", 128'(inf5), 128'(e.inflight));
            chk("s5_in_ready", 128'(rdy5), 128'(e.rdy));
`ifdef CTRL_PIPE_PERF_EN
            chk("s5_stall_cycles", 128'(stc5), 128'(e.stc));
            chk("s5_retired", 128'(ret5), 128'(e.ret));
`endif
        end
    end

    localparam logic [15:0] ADD_I = 16'h12A5;
    localparam logic [15:0] LDR_I = 16'h6283;
    localparam logic [15:0] AND_I = 16'h5042;
    localparam logic [15:0] IDLE  = 16'h0000;

    initial begin
        logic [3:0] ops[6];
        logic [15:0] ins;
        ops[0] = 4'h1; ops[1] = 4'h5; ops[2] = 4'h9; ops[3] = 4'h6; ops[4] = 4'h7; ops[5] = 4'h0;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 5; k++) begin m_v[d][k] = 0; m_w[d][k] = '0; end
            m_ill[d] = 0; m_stc[d] = 0; m_ret[d] = 0;
        end

        repeat (3) cyc(0, IDLE, 0, 1, 1);
        cyc(0, IDLE, 0, 1, 0);
        look;
        chk("ready_after_reset", 128'(rdy3), 128'(1));

        // ADD R1,R2,#5 reaches WB three cycles after acceptance
        cyc(1, ADD_I, 0, 1, 0); look;
        chk("add_stage0", 128'(v3), 128'(3'b001));
        cyc(0, IDLE, 0, 1, 0); look;
        cyc(0, IDLE, 0, 1, 0); look;
        chk("add_wb_valid", 128'(v3), 128'(3'b100));
        chk("add_sr2mux", 128'(ctrl3[2].sr2mux_sel), 128'(1));
        chk("add_aluop", 128'(ctrl3[2].aluop), 128'(alu_add));
        cyc(0, IDLE, 0, 1, 0); look;

        // LDR held in MEM for four cycles
        cyc(1, LDR_I, 0, 1, 0); look;
        cyc(0, IDLE, 0, 0, 0); look;
        chk("ldr_stall_ready", 128'(rdy3), 128'(0));
        chk("ldr_stall_wb", 128'(v3[2]), 128'(0));
        for (int n = 0; n < 3; n++) begin
            cyc(1, ADD_I, 0, 0, 0); look;
            chk("ldr_stall_ready", 128'(rdy3), 128'(0));
            chk("ldr_stall_wb", 128'(v3[2]), 128'(0));
        end
        cyc(0, IDLE, 0, 1, 0); look;
        chk("ldr_in_wb", 128'(v3), 128'(3'b100));
        chk("ldr_wb_read", 128'(ctrl3[2].mem_read), 128'(1));
        repeat (4) cyc(0, IDLE, 0, 1, 0);

        // flush with three in flight
        cyc(1, ADD_I, 0, 1, 0);
        cyc(1, 16'h9FFF, 0, 1, 0);
        cyc(1, AND_I, 0, 1, 0); look;
        chk("flush_pre_valid", 128'(v3), 128'(3'b111));
        cyc(0, IDLE, 1, 1, 0); look;
        chk("flush_valid", 128'(v3), 128'(3'b100));
        chk("flush_inflight", 128'(inf3), 128'(1));

        // unknown opcode 4'hD
        cyc(1, 16'hD123, 0, 1, 0); look;
        chk("illegal_pulse", 128'(ill3), 128'(1));
        chk("illegal_s0_valid", 128'(v3[0]), 128'(0));
        cyc(0, IDLE, 0, 1, 0); look;
        chk("illegal_one_cycle", 128'(ill3), 128'(0));

        // reset while the 5-stage pipe is stalled
        cyc(1, LDR_I, 0, 1, 0);
        repeat (3) cyc(0, IDLE, 0, 1, 0);
        cyc(0, IDLE, 0, 0, 0);
        cyc(0, IDLE, 0, 0, 0); look;
        chk("s5_stalled", 128'(rdy5), 128'(0));
        cyc(1, ADD_I, 0, 0, 1); look;
        chk("s5_rst_valid", 128'(v5), 128'(0));
        chk("s5_rst_ready", 128'(rdy5), 128'(1));

        // ten stall cycles and seven retirements from a clean reset
        cyc(0, IDLE, 0, 1, 0);
        cyc(1, LDR_I, 0, 1, 0);
        cyc(0, IDLE, 0, 1, 0);
        repeat (10) cyc(0, IDLE, 0, 0, 0);
        cyc(0, IDLE, 0, 1, 0);
        repeat (6) cyc(1, ADD_I, 0, 1, 0);
        repeat (4) cyc(0, IDLE, 0, 1, 0);
        look;
`ifdef CTRL_PIPE_PERF_EN
        chk("perf_stall_cycles", 128'(stc3), 128'(10));
        chk("perf_retired", 128'(ret3), 128'(7));
`endif
        chk("perf_drained", 128'(v3), 128'(0));

        for (int n = 0; n < 3000; n++) begin
            ins = 16'($urandom);
            if ($urandom_range(0, 9) < 8) ins[15:12] = ops[$urandom_range(0, 5)];
            cyc(1'($urandom_range(0, 3) != 0), ins, 1'($urandom_range(0, 19) == 0),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 199) == 0));
        end
        cyc(0, IDLE, 0, 1, 0);
        look;
        look;
        chk("queue_drain", 128'(q3.size() + q5.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
